// File: rtl/matrix_scan.sv
// Row-multiplexed scan driver for a 6x6 LED matrix: latches one bitmap per frame,
// blanks before each row, and applies 4-bit PWM within each row's lit window.
module matrix_scan #(
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [35:0] img,
    input  logic [3:0]  brightness,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        frame_start,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BLANKING = 2'd1,
        LIT      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [35:0]   fb_q, fb_d;
    logic [3:0]    bl_q, bl_d;
    logic [5:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;
    logic          fs_q, fs_d;
    logic [5:0]    cur_bits;

    // The dwell counter runs across the whole row: 0..BLANK-1 blank, BLANK..DWELL-1 lit.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        pwm_d   = pwm_q;
        fb_d    = fb_q;
        bl_d    = bl_q;
        fs_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            r_d     = 3'd0;
            cnt_d   = '0;
            pwm_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANKING;
                    r_d     = 3'd0;
                    cnt_d   = '0;
                    pwm_d   = 4'd0;
                    fb_d    = img;
                    bl_d    = brightness;
                    fs_d    = 1'b1;
                end
                BLANKING: begin
                    cnt_d = cnt_q + 1'b1;
                    pwm_d = 4'd0;
                    if (cnt_q == BLANK_END) begin
                        state_d = LIT;
                    end
                end
                LIT: begin
                    if (cnt_q == DWELL_END) begin
                        state_d = BLANKING;
                        cnt_d   = '0;
                        pwm_d   = 4'd0;
                        if (r_q == 3'd5) begin
                            r_d  = 3'd0;
                            fb_d = img;
                            bl_d = brightness;
                            fs_d = 1'b1;
                        end else begin
                            r_d = r_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        pwm_d = pwm_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_d)
            3'd0:    cur_bits = fb_q[5:0];
            3'd1:    cur_bits = fb_q[11:6];
            3'd2:    cur_bits = fb_q[17:12];
            3'd3:    cur_bits = fb_q[23:18];
            3'd4:    cur_bits = fb_q[29:24];
            3'd5:    cur_bits = fb_q[35:30];
            default: cur_bits = 6'd0;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        row_d = 6'd0;
        col_d = 6'd0;
        if (state_d == LIT) begin
            row_d = 6'b000001 << r_d;
            if (pwm_d < bl_q) begin
                col_d = cur_bits;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= 3'd0;
            cnt_q   <= '0;
            pwm_q   <= 4'd0;
            fb_q    <= 36'd0;
            bl_q    <= 4'd0;
            row_q   <= 6'd0;
            col_q   <= 6'd0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            fb_q    <= fb_d;
            bl_q    <= bl_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fs_q    <= fs_d;
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign frame_start = fs_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Self-checking bench for matrix_scan: frame-relative arithmetic model plus
// hand-computed checks of glyph scan, PWM counts, enable and async reset.
module tb_matrix_scan;

    localparam int DWELL = 32;
    localparam int BLANK = 4;
    localparam int FRAME = 6 * DWELL;
    localparam logic [35:0] GLYPH = {6'b100001, 6'b100001, 6'b111111,
                                     6'b100001, 6'b100001, 6'b111111};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [35:0] img;
    logic [3:0]  brightness;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        frame_start;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .img         (img),
        .brightness  (brightness),
        .row         (row),
        .col         (col),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // m_k is the 1-based cycle index inside the current frame (1 = frame_start cycle).
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [35:0] m_fb = '0;
    int          m_bl = 0;

    always @(posedge clk or posedge rst) begin
        if (rst || !enable) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (!m_active || m_k == FRAME) begin
            m_active = 1'b1;
            m_k      = 1;
            m_fb     = img;
            m_bl     = int'(brightness);
        end else begin
            m_k++;
        end
    end

    // ---------------- compare process ----------------
    int  cyc = 0;
    int  last_fs = -1;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [5:0] e_row, e_col;
        logic       e_fs;
        int pos, rr, phase;
        e_row = 6'd0;
        e_col = 6'd0;
        e_fs  = 1'b0;
        if (m_active) begin
            pos  = (m_k - 1) % DWELL;
            rr   = (m_k - 1) / DWELL;
            e_fs = (m_k == 1);
            if (pos >= BLANK) begin
                e_row = 6'b000001 << rr;
                phase = (pos - BLANK) % 16;
                if (phase < m_bl) e_col = m_fb[6*rr +: 6];
            end
        end
        check("model_row", 36'(row), 36'(e_row));
        check("model_col", 36'(col), 36'(e_col));
        check("model_frame_start", 36'(frame_start), 36'(e_fs));
        check("row_onehot", 36'($countones(row) <= 1), 36'd1);
        if (!m_active) last_fs = -1;
        if (frame_start) begin
            if (last_fs >= 0) check("frame_spacing", 36'(cyc - last_fs), 36'(FRAME));
            last_fs = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        check("wait_fs_timeout", 36'(seen), 36'd1);
    endtask

    // Counts from the current negedge over n cycles.
    task automatic count_cycles(input int n, inout int lit, inout int rowon);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (col != 6'd0) lit++;
            if (row != 6'd0) rowon++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lit, rowon;
        rst = 1'b1; enable = 1'b0; img = GLYPH; brightness = 4'd15;
        step(3);
        check("reset_row", 36'(row), 36'd0);
        check("reset_col", 36'(col), 36'd0);
        check("reset_fs", 36'(frame_start), 36'd0);

        // Glyph scan, brightness 15
        rst = 1'b0; enable = 1'b1;
        step(1);
        check("first_fs", 36'(frame_start), 36'd1);
        check("first_blank_row", 36'(row), 36'd0);
        step(BLANK);
        check("row0_lit_row", 36'(row), 36'(6'b000001));
        check("row0_pwm0_col", 36'(col), 36'(6'b111111));
        step(15);
        check("row0_pwm15_col", 36'(col), 36'd0);
        check("row0_pwm15_row", 36'(row), 36'(6'b000001));
        step(16);
        check("row1_blank_row", 36'(row), 36'd0);
        step(1);
        check("row1_lit_row", 36'(row), 36'(6'b000010));
        check("row1_lit_col", 36'(col), 36'(6'b100001));

        // Frame coherence: blank img during row 2
        step(32);
        img = 36'd0;
        step(32);
        check("row3_old_bitmap_row", 36'(row), 36'(6'b001000));
        check("row3_old_bitmap_col", 36'(col), 36'(6'b111111));
        wait_fs();
        lit = 0; rowon = 0;
        count_cycles(FRAME, lit, rowon);
        check("dark_frame_lit", 36'(lit), 36'd0);
        check("dark_frame_rowon", 36'(rowon), 36'(6 * (DWELL - BLANK)));

        // PWM: 8/16, mid-frame brightness change deferred
        img = GLYPH; brightness = 4'd8;
        wait_fs();
        lit = 0; rowon = 0;
        count_cycles(FRAME / 2, lit, rowon);
        brightness = 4'd0;
        step(1);
        count_cycles(FRAME / 2, lit, rowon);
        check("pwm8_frame_lit", 36'(lit), 36'd96);
        wait_fs();
        lit = 0; rowon = 0;
        count_cycles(FRAME, lit, rowon);
        check("pwm0_frame_lit", 36'(lit), 36'd0);
        check("pwm0_frame_rowon", 36'(rowon), 36'(6 * (DWELL - BLANK)));

        // Enable drop in row 4 lit, then restart
        brightness = 4'd15;
        wait_fs();
        step(139);
        check("row4_before_drop", 36'(row), 36'(6'b010000));
        enable = 1'b0;
        step(1);
        check("drop_row", 36'(row), 36'd0);
        check("drop_col", 36'(col), 36'd0);
        enable = 1'b1;
        step(1);
        check("reenable_fs", 36'(frame_start), 36'd1);
        step(BLANK);
        check("reenable_row0", 36'(row), 36'(6'b000001));

        // Async reset mid row 3 lit
        wait_fs();
        step(109);
        check("row3_before_rst", 36'(row), 36'(6'b001000));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_row", 36'(row), 36'd0);
        check("async_rst_col", 36'(col), 36'd0);
        check("async_rst_fs", 36'(frame_start), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        check("post_rst_fs", 36'(frame_start), 36'd1);

        // Randomized phase
        for (int it = 0; it < 14; it++) begin
            step($urandom_range(1, 300));
            img = {$urandom(), $urandom()};
            brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                step($urandom_range(1, 5));
                enable = 1'b1;
            end
        end
        step(FRAME + 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
